// File: rtl/rs_conv_deinterleaver.sv
// Forney convolutional deinterleaver (I branches, unit delay M) with sync-byte lock tracking.
// Emits only whole, packet-aligned codewords, and only once the shared delay RAM is primed.
module rs_conv_deinterleaver #(
  parameter int unsigned I         = 12,
  parameter int unsigned M         = 17,
  parameter int unsigned PKT       = 204,
  parameter int unsigned SYNC_LOCK = 3,
  parameter int unsigned SYNC_LOSE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CE,
  input  logic [7:0] input_byte,
  output logic [7:0] Out_byte,
  output logic       CEO,
  output logic       Sync_out,
  output logic       Locked
);

  localparam int unsigned Depth   = M * I * (I - 1) / 2;
  localparam int unsigned FillMax = I * (I - 1) * M;
  localparam int unsigned AW      = $clog2(Depth + 1);
  localparam int unsigned DW      = $clog2((I - 1) * M);
  localparam int unsigned BW      = $clog2(I);
  localparam int unsigned PW      = $clog2(PKT);
  localparam int unsigned FW      = $clog2(FillMax + 1);
  localparam int unsigned CntMax  = (SYNC_LOCK > SYNC_LOSE) ? SYNC_LOCK : SYNC_LOSE;
  localparam int unsigned HW      = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StSearch, StVerify, StLock} state_e;

  state_e          state_q, state_d;
  logic            ce_q;
  logic [7:0]      byte_q;
  logic [PW-1:0]   pos_q, pos_d;
  logic [HW-1:0]   hits_q, hits_d, hits_inc;
  logic [HW-1:0]   misses_q, misses_d, misses_inc;
  logic [BW-1:0]   branch_q;
  logic [DW-1:0]   ptr_q [I];
  logic [FW-1:0]   fill_q;
  logic [PW-1:0]   opkt_q;
  logic            is_sync, at_start, wr_en, lose, bypass, mem_we;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   base_tab [I];
  logic [DW-1:0]   last_tab [I];
  logic [7:0]      mem [Depth];
  logic [7:0]      ram_q;
  logic            out_v_q, byp_q;
  logic [7:0]      byp_byte_q;

  // Branch b occupies a contiguous RAM window of (I-1-b)*M bytes; the last branch has none.
  for (genvar g = 0; g < I; g++) begin : g_tab
    assign base_tab[g] = AW'(M * (g * (I - 1) - g * (g - 1) / 2));
    assign last_tab[g] = DW'((g < I - 1) ? (I - 1 - g) * M - 1 : 0);
  end

  assign is_sync    = (byte_q == 8'h47) || (byte_q == 8'hB8);
  assign at_start   = (pos_q == '0);
  assign hits_inc   = hits_q + HW'(1);
  assign misses_inc = misses_q + HW'(1);
  assign bypass     = (branch_q == BW'(I - 1));
  assign addr       = base_tab[branch_q] + AW'(ptr_q[branch_q]);
  assign mem_we     = wr_en && !bypass;
  assign Locked     = (state_q == StLock);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    wr_en    = 1'b0;
    lose     = 1'b0;
    if (ce_q) begin
      pos_d = (pos_q == PW'(PKT - 1)) ? '0 : pos_q + PW'(1);
      unique case (state_q)
        StSearch: begin
          if (is_sync) begin
            state_d = StVerify;
            pos_d   = PW'(1);
            hits_d  = HW'(1);
          end
        end
        StVerify: begin
          if (at_start) begin
            if (!is_sync) begin
              state_d = StSearch;
            end else if (hits_inc >= HW'(SYNC_LOCK)) begin
              // The confirming sync byte is the first byte into the delay line.
              state_d  = StLock;
              misses_d = '0;
              wr_en    = 1'b1;
            end else begin
              hits_d = hits_inc;
            end
          end
        end
        StLock: begin
          wr_en = 1'b1;
          if (at_start) begin
            if (is_sync) begin
              misses_d = '0;
            end else if (misses_inc >= HW'(SYNC_LOSE)) begin
              state_d = StSearch;
              wr_en   = 1'b0;
              lose    = 1'b1;
            end else begin
              misses_d = misses_inc;
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  // Read-first RAM: each visit returns the byte written D_b visits earlier.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ram_q     <= mem[addr];
      mem[addr] <= byte_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ce_q       <= 1'b0;
      byte_q     <= '0;
      state_q    <= StSearch;
      pos_q      <= '0;
      hits_q     <= '0;
      misses_q   <= '0;
      branch_q   <= '0;
      fill_q     <= '0;
      opkt_q     <= '0;
      out_v_q    <= 1'b0;
      byp_q      <= 1'b0;
      byp_byte_q <= '0;
      Out_byte   <= '0;
      CEO        <= 1'b0;
      Sync_out   <= 1'b0;
      for (int b = 0; b < I; b++) ptr_q[b] <= '0;
    end else begin
      ce_q     <= CE;
      byte_q   <= input_byte;
      state_q  <= state_d;
      pos_q    <= pos_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;

      if (lose) begin
        branch_q <= '0;
        fill_q   <= '0;
        for (int b = 0; b < I; b++) ptr_q[b] <= '0;
      end else if (wr_en) begin
        branch_q <= bypass ? '0 : branch_q + BW'(1);
        if (!bypass) begin
          ptr_q[branch_q] <= (ptr_q[branch_q] == last_tab[branch_q]) ? '0
                                                                     : ptr_q[branch_q] + DW'(1);
        end
        if (fill_q != FW'(FillMax)) fill_q <= fill_q + FW'(1);
      end

      out_v_q    <= wr_en && (fill_q == FW'(FillMax));
      byp_q      <= bypass;
      byp_byte_q <= byte_q;

      CEO      <= out_v_q;
      Sync_out <= out_v_q && (opkt_q == '0);
      if (out_v_q) Out_byte <= byp_q ? byp_byte_q : ram_q;

      if (lose) begin
        opkt_q <= '0;
      end else if (out_v_q) begin
        opkt_q <= (opkt_q == PW'(PKT - 1)) ? '0 : opkt_q + PW'(1);
      end
    end
  end

endmodule
